// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - receive-side decoder for the multiplexed 7-segment scan bus
//
// Samples the ledsel/led scan bus, filters scan glitches, decodes each
// segment pattern back to a BCD nibble and assembles complete 8-digit frames.
//
// Ports:
//   CP        system clock, rising edge
//   rst       asynchronous active-low reset
//   EN        decoder enable (filter and frame assembly freeze while low)
//   ledsel    digit select, active-low one-hot, bit0 = rightmost digit
//   led       segments a..g, active-high, led[0] = a
//   digits    last complete frame, nibble i = digit position i
//   frame_vld one-cycle pulse when digits updates
//   seg_err   sticky: an accepted pattern was not a legal glyph
//   sel_err   sticky: an accepted ledsel was not one-hot-low
//   stale     no frame completed for TIMEOUT_CYC cycles
//   changed   (CHANGE_DET_EN only) new frame differs from the previous one
//
// Optional feature macro: CHANGE_DET_EN adds the changed output.

module seg_scan_decoder #(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        CP,
    input  logic        rst,
    input  logic        EN,
    input  logic [7:0]  ledsel,
    input  logic [6:0]  led,
    output logic [31:0] digits,
    output logic        frame_vld,
    output logic        seg_err,
    output logic        sel_err,
`ifdef CHANGE_DET_EN
    output logic        changed,
`endif
    output logic        stale
);

    typedef enum logic [1:0] {HUNT, COLLECT, DONE} state_t;

    localparam logic [7:0]  STB_LAST = 8'(STABLE_CYC - 1);
    localparam logic [15:0] TO_LIM   = 16'(TIMEOUT_CYC);
    // Idle bus value: nothing selected, all segments dark.
    localparam logic [14:0] IDLE_SMP = {8'hFF, 7'h00};

    // Two-stage synchroniser plus one history stage for the stability compare.
    logic [14:0] smp1, smp2, smp3;
    logic        en1, en2, en3;

    logic [7:0]  cnt;
    logic        fired;
    logic        accept;

    logic [7:0]  acc_sel;
    logic [6:0]  acc_led;
    logic [7:0]  acc_bit;
    logic [2:0]  acc_pos;
    logic        sel_ok;
    logic        take;
    logic [3:0]  nib;
    logic        glyph_bad;

    state_t      state;
    logic [7:0]  mask;
    logic [31:0] shadow;
    logic [15:0] tcnt;
`ifdef CHANGE_DET_EN
    logic        have_frame;
`endif

    // Synchroniser and glitch filter. fired blocks a second accept of the
    // same stable value; it starts set so an idle bus after reset is ignored.
    always_ff @(posedge CP or negedge rst) begin
        if (!rst) begin
            smp1  <= IDLE_SMP;
            smp2  <= IDLE_SMP;
            smp3  <= IDLE_SMP;
            en1   <= 1'b1;
            en2   <= 1'b1;
            en3   <= 1'b1;
            cnt   <= 8'd0;
            fired <= 1'b1;
        end else begin
            smp1 <= {ledsel, led};
            smp2 <= smp1;
            smp3 <= smp2;
            en1  <= EN;
            en2  <= en1;
            en3  <= en2;
            if (en2 && !en3) begin
                // Re-enable: restart so the value now on the bus is re-judged.
                cnt   <= 8'd0;
                fired <= 1'b0;
            end else if (en2) begin
                if (smp2 != smp3) begin
                    cnt   <= 8'd0;
                    fired <= 1'b0;
                end else begin
                    if (cnt != 8'hFF) begin
                        cnt <= cnt + 8'd1;
                    end
                    if (accept) begin
                        fired <= 1'b1;
                    end
                end
            end
        end
    end

    // The accepted value is the one held in smp3 (the value that was stable).
    assign accept  = en2 && en3 && !fired && (cnt == STB_LAST);
    assign acc_sel = smp3[14:7];
    assign acc_led = smp3[6:0];
    assign acc_bit = ~acc_sel;
    assign sel_ok  = (acc_bit != 8'h00) && ((acc_bit & (acc_bit - 8'd1)) == 8'h00);
    assign take    = accept && sel_ok;

    always_comb begin
        acc_pos = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (acc_bit[i]) begin
                acc_pos = 3'(i);
            end
        end
    end

    always_comb begin
        glyph_bad = 1'b0;
        case (acc_led)
            7'h3F:   nib = 4'h0;
            7'h06:   nib = 4'h1;
            7'h5B:   nib = 4'h2;
            7'h4F:   nib = 4'h3;
            7'h66:   nib = 4'h4;
            7'h6D:   nib = 4'h5;
            7'h7D:   nib = 4'h6;
            7'h07:   nib = 4'h7;
            7'h7F:   nib = 4'h8;
            7'h6F:   nib = 4'h9;
            7'h00:   nib = 4'hE;
            default: begin
                nib       = 4'hF;
                glyph_bad = 1'b1;
            end
        endcase
    end

    // Frame assembly. The mask-full check happens the cycle after the last
    // write, and the frame_vld register makes it visible one cycle later.
    always_ff @(posedge CP or negedge rst) begin
        if (!rst) begin
            state     <= HUNT;
            mask      <= 8'h00;
            shadow    <= 32'h0;
            digits    <= 32'h0;
            frame_vld <= 1'b0;
            seg_err   <= 1'b0;
            sel_err   <= 1'b0;
`ifdef CHANGE_DET_EN
            changed    <= 1'b0;
            have_frame <= 1'b0;
`endif
        end else begin
            frame_vld <= 1'b0;
`ifdef CHANGE_DET_EN
            changed <= 1'b0;
`endif
            if (accept && glyph_bad) begin
                seg_err <= 1'b1;
            end
            if (accept && !sel_ok) begin
                sel_err <= 1'b1;
            end
            case (state)
                HUNT: begin
                    if (take && (acc_sel == 8'hFE)) begin
                        shadow[3:0] <= nib;
                        mask        <= 8'h01;
                        state       <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (mask == 8'hFF) begin
                        digits    <= shadow;
                        frame_vld <= 1'b1;
`ifdef CHANGE_DET_EN
                        changed    <= have_frame && (shadow != digits);
                        have_frame <= 1'b1;
`endif
                        state     <= DONE;
                    end else if (take) begin
                        shadow[{acc_pos, 2'b00} +: 4] <= nib;
                        mask                          <= mask | acc_bit;
                    end
                end
                DONE: begin
                    // An accept landing here already belongs to the next frame.
                    if (take) begin
                        shadow[{acc_pos, 2'b00} +: 4] <= nib;
                        mask                          <= acc_bit;
                    end else begin
                        mask <= 8'h00;
                    end
                    state <= COLLECT;
                end
                default: state <= HUNT;
            endcase
        end
    end

    // Frame watchdog; keeps running while EN is low.
    always_ff @(posedge CP or negedge rst) begin
        if (!rst) begin
            tcnt <= 16'd0;
        end else if (frame_vld) begin
            tcnt <= 16'd0;
        end else if (tcnt != 16'hFFFF) begin
            tcnt <= tcnt + 16'd1;
        end
    end

    assign stale = (tcnt >= TO_LIM);

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive side of the multiplexed 7-segment display bus driven by the digital-clock top (`ledsel`/`led`).
- Filters scan glitches, decodes each segment pattern back to a BCD digit, and assembles complete 8-digit frames.
- Used as a display loopback checker in system builds and as a readback path for the alarm/time-compare logic.

Parameters:
- STABLE_CYC, 4: consecutive identical `ledsel`/`led` samples required before a digit is accepted (1..255).
- TIMEOUT_CYC, 4096: cycles with no completed frame before `stale` asserts (counter 16 bits, saturating).

Ports:
- CP  input  1  system clock, all logic rising-edge.
- rst  input  1  asynchronous active-low reset.
- EN  input  1  decoder enable; when low, filter and frame mask hold and no captures occur.
- ledsel  input  8  digit select, active-low one-hot; bit0 = rightmost digit (seconds units).
- led  input  7  segments, active-high; led[0]=a … led[6]=g.
- digits  output  32  last complete frame, nibble i = digit position i.
- frame_vld  output  1  one-cycle pulse when `digits` updates.
- seg_err  output  1  sticky: an accepted pattern was not a legal glyph.
- sel_err  output  1  sticky: `ledsel` had zero or more than one bit low while stable.
- stale  output  1  high while no frame has completed for TIMEOUT_CYC cycles.

Behaviour:
- Reset (rst=0, async): digits=32'h0, frame_vld=0, seg_err=0, sel_err=0, stale=0; filter counter, frame mask and timeout counter cleared; state=HUNT.
- Inputs are registered twice (synchroniser) before any use; all latencies below count from the second register.
- Filter:
  - Counter increments while the sampled {ledsel,led} equals the previous sample.
  - Counter resets to 0 on any change.
  - Accept strobe fires once when the counter reaches STABLE_CYC-1; no re-fire until the input changes.
- Glyph decode:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - 00 (blank) decodes to 4'hE with no error.
  - Any other pattern decodes to 4'hF and sets seg_err.
- Select check: an accepted strobe with a non-one-hot ledsel sets sel_err; that sample is discarded and the mask is unchanged.
- FSM:
  - HUNT: ignore accepts until position 0 is accepted. Store it in the shadow buffer, mask=8'h01, go to COLLECT.
  - COLLECT: each valid accept writes the shadow nibble and sets its mask bit. Rewriting an already-set position overwrites the nibble; the mask stays set.
  - COLLECT → DONE when mask==8'hFF (checked the cycle after the write).
  - DONE (1 cycle): copy shadow to digits, pulse frame_vld, clear mask, go to COLLECT. The next frame needs all 8 positions again.
  - Latency: last-digit accept → frame_vld = 2 cycles.
- Timeout:
  - Counter clears on frame_vld and increments otherwise, saturating.
  - stale=1 when count ≥ TIMEOUT_CYC; stale drops the cycle after the next frame_vld.
- EN=0:
  - Accept strobes are suppressed; FSM, mask and filter freeze; the timeout counter still runs.
  - On EN rising, the filter restarts from 0.
- Sticky errors clear only on reset.

Optional Feature:
- CHANGE_DET_EN defined:
  - Adds output `changed` (1 bit), pulsing together with frame_vld when the new frame differs from the previous `digits`.
  - `changed` is 0 on the first frame after reset.
- CHANGE_DET_EN not defined: port and compare logic are absent.

Test Plan:
- Scan "12345906" (pos7..0), 10 cycles per digit, STABLE_CYC=4 → frame_vld pulses once per full scan; digits=32'h12345906.
- 2-cycle glitch pattern 0x7F on pos3 between valid scans → no capture; digits unchanged; seg_err=0.
- Pos2 shows 0x49 for 10 cycles → seg_err=1 (sticky); that nibble reads F on the next frame_vld.
- ledsel=8'hFC stable 10 cycles → sel_err=1; mask unchanged; no frame_vld until a full clean scan follows.
- Stop scanning for 4096 cycles → stale=1; resume full scan → frame_vld, then stale=0.
- Reset asserted mid-frame (after pos0..4) → all outputs 0 immediately; after release, FSM waits in HUNT for pos0 and the first frame_vld follows a full 8-digit scan.
